// File: rtl/store_align_unit_if.sv
// ----------------------------------------------------------------------------
// store_align_unit_if
//   Groups the store request handshake, the data-memory write port and the
//   completion signals of store_align_unit into one bundle.
//
//   master : the side that issues store requests and models the memory
//            (execute stage / memory); drives reqValid, reqAddr, reqData,
//            reqSize and memReady.
//   slave  : store_align_unit itself; drives reqReady, memWrite, memAddr,
//            memWdata, memStrobe, doneValid and doneError.
// ----------------------------------------------------------------------------
interface store_align_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [1:0]  reqSize;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memStrobe;
    logic        memReady;
    logic        doneValid;
    logic        doneError;

    modport master (
        output reqValid, reqAddr, reqData, reqSize, memReady,
        input  reqReady, memWrite, memAddr, memWdata, memStrobe, doneValid, doneError
    );

    modport slave (
        input  reqValid, reqAddr, reqData, reqSize, memReady,
        output reqReady, memWrite, memAddr, memWdata, memStrobe, doneValid, doneError
    );
endinterface

// File: rtl/store_align_unit.sv
// ----------------------------------------------------------------------------
// store_align_unit
//   Store-side alignment unit between the execute stage and the data-memory
//   write port. A store request (byte address, LSB-justified data, size) is
//   turned into one or two lane-aligned 32-bit bus beats with byte strobes.
//   Stores crossing a word boundary are split into two beats (or rejected when
//   ALLOW_MISALIGNED = 0). A stalled beat is abandoned after TIMEOUT_CYCLES.
//
//   Ports
//     clk    : clock, rising edge
//     reset  : synchronous, active-high
//     bus    : store_align_unit_if.slave
//              reqValid/reqReady/reqAddr/reqData/reqSize : request handshake
//              memWrite/memReady/memAddr/memWdata/memStrobe : memory write beat
//              doneValid/doneError : one-cycle completion pulse and status
// ----------------------------------------------------------------------------
module store_align_unit #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES   = 255    // 1..255
) (
    input  logic         clk,
    input  logic         reset,
    store_align_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      nextState;

    logic [29:0] wordQ;        // word index of the first beat
    logic [63:0] shiftedQ;     // data spread over two consecutive words
    logic [7:0]  strobeQ;      // byte enables over the same two words
    logic        errorQ;       // status reported with doneValid
    logic [7:0]  stallCount;   // stalled cycles of the current beat

    logic [1:0]  off;
    logic [3:0]  sizeMask;
    logic        sizeIllegal;
    logic        misalignError;
    logic        acceptError;
    logic        accept;
    logic        inBeat;
    logic        timeout;
    logic [63:0] shiftedNow;
    logic [7:0]  strobeNow;

    assign off = bus.reqAddr[1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        sizeMask    = 4'b0000;
        sizeIllegal = 1'b0;
        case (bus.reqSize)
            2'b00:   sizeMask = 4'b0001;
            2'b01:   sizeMask = 4'b0011;
            2'b10:   sizeMask = 4'b1111;
            default: sizeIllegal = 1'b1;
        endcase
    end

    // Any non-zero offset on a half or word store is rejected when splitting
    // is disabled, even if the store would fit inside one word.
    assign misalignError = (ALLOW_MISALIGNED == 1'b0) && (off != 2'b00) && (bus.reqSize != 2'b00);
    assign acceptError   = sizeIllegal || misalignError;
    assign accept        = bus.reqValid && (state == IDLE);

    // Shifting across 64 bits places the overflow bytes directly in the
    // second word's lanes, so beat 1 needs no extra alignment logic.
    assign shiftedNow = {32'b0, bus.reqData} << {off, 3'b000};
    assign strobeNow  = {4'b0000, sizeMask} << off;

    assign inBeat  = (state == BEAT0) || (state == BEAT1);
    assign timeout = inBeat && !bus.memReady && (stallCount == TIMEOUT_LAST);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (accept) nextState = acceptError ? RESP : BEAT0;
            BEAT0: begin
                if (bus.memReady)  nextState = (strobeQ[7:4] != 4'b0000) ? BEAT1 : RESP;
                else if (timeout)  nextState = RESP;
            end
            BEAT1: if (bus.memReady || timeout) nextState = RESP;
            RESP:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wordQ      <= '0;
            shiftedQ   <= '0;
            strobeQ    <= '0;
            errorQ     <= 1'b0;
            stallCount <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                wordQ    <= bus.reqAddr[31:2];
                shiftedQ <= shiftedNow;
                strobeQ  <= strobeNow;
                errorQ   <= acceptError;
            end else if (timeout) begin
                errorQ   <= 1'b1;
            end
            // A handshake (or any non-beat cycle) clears the count, so each
            // beat starts counting from zero.
            if (inBeat && !bus.memReady) stallCount <= stallCount + 8'd1;
            else                         stallCount <= '0;
        end
    end

    always_comb begin
        bus.memAddr   = '0;
        bus.memWdata  = '0;
        bus.memStrobe = '0;
        case (state)
            BEAT0: begin
                bus.memAddr   = {wordQ, 2'b00};
                bus.memWdata  = shiftedQ[31:0];
                bus.memStrobe = strobeQ[3:0];
            end
            BEAT1: begin
                // Word index wraps naturally: 0xFFFFFFFC is followed by 0x0.
                bus.memAddr   = {wordQ + 30'd1, 2'b00};
                bus.memWdata  = shiftedQ[63:32];
                bus.memStrobe = strobeQ[7:4];
            end
            default: ;
        endcase
    end

    assign bus.reqReady  = (state == IDLE);
    assign bus.memWrite  = inBeat;
    assign bus.doneValid = (state == RESP);
    assign bus.doneError = (state == RESP) && errorQ;

endmodule

// File: tb/tb_store_align_unit.sv
// ----------------------------------------------------------------------------
// tb_store_align_unit
//   Two units share the same stimulus: dutA splits word-crossing stores,
//   dutB rejects misaligned ones. Both use a short timeout. Each transaction
//   is compared against a byte-level reference model that also replays the
//   memReady pattern to predict handshakes, timeouts and completion cycle.
// ----------------------------------------------------------------------------
module tb_store_align_unit;

    localparam int TIMEOUT = 4;
    localparam int PERIODS = 16;
    localparam logic [39:0] ALL_HIGH = 40'hFF_FFFF_FFFF;

    typedef struct packed {
        logic        reqReady;
        logic        memWrite;
        logic [31:0] memAddr;
        logic [31:0] memWdata;
        logic [3:0]  memStrobe;
        logic        doneValid;
        logic        doneError;
    } sample_t;

    typedef struct packed {
        int              hs;           // accepted beats
        logic [1:0][31:0] addr;
        logic [1:0][31:0] data;
        logic [1:0][3:0]  strb;
        logic            err;
        int              doneK;        // period (after accept edge) of doneValid
        int              writeCycles;  // periods with memWrite high
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic        reqValid = 1'b0;
    logic [31:0] reqAddr  = '0;
    logic [31:0] reqData  = '0;
    logic [1:0]  reqSize  = '0;
    logic        memReady = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_align_unit_if ifA ();
    store_align_unit_if ifB ();

    assign ifA.reqValid = reqValid;  assign ifB.reqValid = reqValid;
    assign ifA.reqAddr  = reqAddr;   assign ifB.reqAddr  = reqAddr;
    assign ifA.reqData  = reqData;   assign ifB.reqData  = reqData;
    assign ifA.reqSize  = reqSize;   assign ifB.reqSize  = reqSize;
    assign ifA.memReady = memReady;  assign ifB.memReady = memReady;

    store_align_unit #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(TIMEOUT)) dutA (
        .clk(clk), .reset(reset), .bus(ifA.slave));
    store_align_unit #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(TIMEOUT)) dutB (
        .clk(clk), .reset(reset), .bus(ifB.slave));

    function automatic sample_t sampleOf(input int d);
        sample_t s;
        if (d == 0) s = '{ifA.reqReady, ifA.memWrite, ifA.memAddr, ifA.memWdata, ifA.memStrobe, ifA.doneValid, ifA.doneError};
        else        s = '{ifB.reqReady, ifB.memWrite, ifB.memAddr, ifB.memWdata, ifB.memStrobe, ifB.doneValid, ifB.doneError};
        return s;
    endfunction

    // Reference model: place each data byte i at byte position off+i of a
    // two-word window, enable the first 1/2/4 of them, then replay the
    // memReady pattern beat by beat with a per-beat stall limit.
    function automatic txn_t modelTxn(input bit allow, input logic [31:0] addr, input logic [31:0] data,
                                      input logic [1:0] size, input logic [39:0] mask);
        txn_t m;
        int nBytes, nBeats, k, stall, pos;
        bit stop;
        m = '0;
        m.doneK = 1;
        if (size == 2'b11 || (!allow && addr[1:0] != 2'b00 && size != 2'b00)) begin
            m.err = 1'b1;
            return m;
        end
        nBytes = 1 << size;
        m.addr[0] = {addr[31:2], 2'b00};
        m.addr[1] = m.addr[0] + 32'd4;
        for (int i = 0; i < 4; i++) begin
            pos = int'(addr[1:0]) + i;
            m.data[pos / 4][(pos % 4) * 8 +: 8] = data[i * 8 +: 8];
            if (i < nBytes) m.strb[pos / 4][pos % 4] = 1'b1;
        end
        nBeats = (m.strb[1] != 4'b0000) ? 2 : 1;
        k = 1;
        stop = 1'b0;
        for (int b = 0; b < nBeats && !stop; b++) begin
            stall = 0;
            while (!stop) begin
                if (mask[k]) begin
                    m.hs++;
                    k++;
                    break;
                end
                stall++;
                k++;
                if (stall == TIMEOUT) begin
                    m.err = 1'b1;
                    stop = 1'b1;
                end
            end
        end
        m.doneK = k;
        m.writeCycles = k - 1;
        return m;
    endfunction

    // Drives one request, replays mask[k] on memReady during period k after
    // the accept edge, observes both units and compares them with the model.
    task automatic runTxn(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [39:0] mask,
                          output txn_t obsA, output txn_t obsB);
        txn_t    obs [2];
        txn_t    exp [2];
        sample_t smp, prev [2];
        bit      prevStall [2];
        int      doneCount [2];
        int      viol [2];
        exp[0] = modelTxn(1'b1, addr, data, size, mask);
        exp[1] = modelTxn(1'b0, addr, data, size, mask);
        for (int d = 0; d < 2; d++) begin
            obs[d] = '0;
            obs[d].doneK = -1;
            prev[d] = '0;
            prevStall[d] = 1'b0;
            doneCount[d] = 0;
            viol[d] = 0;
        end

        @(negedge clk);
        reqValid = 1'b1; reqAddr = addr; reqData = data; reqSize = size; memReady = mask[0];
        #1;
        checks++;
        if (ifA.reqReady !== 1'b1 || ifB.reqReady !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_request got A=%b B=%b want 1", name, ifA.reqReady, ifB.reqReady);
        end
        @(posedge clk);

        for (int k = 1; k <= PERIODS; k++) begin
            @(negedge clk);
            reqValid = 1'b0;
            reqAddr  = $urandom;
            reqData  = $urandom;
            reqSize  = 2'($urandom);
            memReady = mask[k];
            #1;
            for (int d = 0; d < 2; d++) begin
                smp = sampleOf(d);
                if (smp.memWrite) obs[d].writeCycles++;
                if (smp.memWrite && prevStall[d] &&
                    (smp.memAddr !== prev[d].memAddr || smp.memWdata !== prev[d].memWdata ||
                     smp.memStrobe !== prev[d].memStrobe)) viol[d]++;
                if (smp.memWrite && memReady) begin
                    if (obs[d].hs < 2) begin
                        obs[d].addr[obs[d].hs] = smp.memAddr;
                        obs[d].data[obs[d].hs] = smp.memWdata;
                        obs[d].strb[obs[d].hs] = smp.memStrobe;
                    end
                    obs[d].hs++;
                end
                if (smp.doneValid) begin
                    doneCount[d]++;
                    if (doneCount[d] == 1) begin
                        obs[d].doneK = k;
                        obs[d].err = smp.doneError;
                    end
                end else if (smp.doneError !== 1'b0) viol[d]++;
                if (smp.reqReady !== (obs[d].doneK > 0 && k > obs[d].doneK)) viol[d]++;
                prevStall[d] = smp.memWrite && !memReady;
                prev[d] = smp;
            end
        end

        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d].hs !== exp[d].hs) begin
                failures++;
                $display("FAIL %s dut%0d handshakes got %0d want %0d", name, d, obs[d].hs, exp[d].hs);
            end
            for (int i = 0; i < 2; i++) begin
                if (i < exp[d].hs && i < obs[d].hs) begin
                    checks++;
                    if (obs[d].addr[i] !== exp[d].addr[i] || obs[d].data[i] !== exp[d].data[i] ||
                        obs[d].strb[i] !== exp[d].strb[i]) begin
                        failures++;
                        $display("FAIL %s dut%0d beat%0d got addr=%h data=%h strb=%b want addr=%h data=%h strb=%b",
                                 name, d, i, obs[d].addr[i], obs[d].data[i], obs[d].strb[i],
                                 exp[d].addr[i], exp[d].data[i], exp[d].strb[i]);
                    end
                end
            end
            checks++;
            if (obs[d].doneK !== exp[d].doneK || obs[d].err !== exp[d].err || doneCount[d] !== 1) begin
                failures++;
                $display("FAIL %s dut%0d done got cycle=%0d err=%b pulses=%0d want cycle=%0d err=%b pulses=1",
                         name, d, obs[d].doneK, obs[d].err, doneCount[d], exp[d].doneK, exp[d].err);
            end
            checks++;
            if (obs[d].writeCycles !== exp[d].writeCycles) begin
                failures++;
                $display("FAIL %s dut%0d write_cycles got %0d want %0d", name, d, obs[d].writeCycles, exp[d].writeCycles);
            end
            checks++;
            if (viol[d] !== 0) begin
                failures++;
                $display("FAIL %s dut%0d protocol got %0d violations want 0", name, d, viol[d]);
            end
        end
        obsA = obs[0];
        obsB = obs[1];
    endtask

    task automatic test_reset();
        sample_t s;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            s = sampleOf(d);
            checks++;
            if (s !== sample_t'{1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state dut%0d got %h want %h", d, s,
                         sample_t'{1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        txn_t a, b;
        runTxn("word_aligned", 32'h0000_1000, 32'hDEAD_BEEF, 2'b10, ALL_HIGH, a, b);
        checks++;
        if (a.hs !== 1 || a.addr[0] !== 32'h1000 || a.data[0] !== 32'hDEAD_BEEF ||
            a.strb[0] !== 4'b1111 || a.doneK !== 2 || a.err !== 1'b0) begin
            failures++;
            $display("FAIL word_aligned_spec got hs=%0d addr=%h data=%h strb=%b done=%0d err=%b want 1 1000 deadbeef 1111 2 0",
                     a.hs, a.addr[0], a.data[0], a.strb[0], a.doneK, a.err);
        end

        runTxn("byte_lane3", 32'h0000_1003, 32'h0000_00A5, 2'b00, ALL_HIGH, a, b);
        checks++;
        if (a.addr[0] !== 32'h1000 || a.data[0] !== 32'hA500_0000 || a.strb[0] !== 4'b1000 ||
            b.data[0] !== 32'hA500_0000) begin
            failures++;
            $display("FAIL byte_lane3_spec got addr=%h dataA=%h strb=%b dataB=%h want 1000 a5000000 1000 a5000000",
                     a.addr[0], a.data[0], a.strb[0], b.data[0]);
        end

        runTxn("half_split", 32'h0000_1003, 32'h0000_BEEF, 2'b01, ALL_HIGH, a, b);
        checks++;
        if (a.hs !== 2 || a.addr[0] !== 32'h1000 || a.data[0] !== 32'hEF00_0000 || a.strb[0] !== 4'b1000 ||
            a.addr[1] !== 32'h1004 || a.data[1] !== 32'h0000_00BE || a.strb[1] !== 4'b0001 || a.doneK !== 3) begin
            failures++;
            $display("FAIL half_split_spec got hs=%0d %h/%h/%b %h/%h/%b done=%0d", a.hs,
                     a.addr[0], a.data[0], a.strb[0], a.addr[1], a.data[1], a.strb[1], a.doneK);
        end

        runTxn("word_wrap", 32'hFFFF_FFFE, 32'h1234_5678, 2'b10, ALL_HIGH, a, b);
        checks++;
        if (a.hs !== 2 || a.addr[1] !== 32'h0000_0000 || a.strb[1] !== 4'b0011 || a.doneK !== 3) begin
            failures++;
            $display("FAIL word_wrap_spec got hs=%0d addr1=%h strb1=%b done=%0d want 2 00000000 0011 3",
                     a.hs, a.addr[1], a.strb[1], a.doneK);
        end
        checks++;
        if (b.writeCycles !== 0 || b.doneK !== 1 || b.err !== 1'b1) begin
            failures++;
            $display("FAIL no_misalign_spec got writes=%0d done=%0d err=%b want 0 1 1", b.writeCycles, b.doneK, b.err);
        end

        runTxn("illegal_size", 32'h0000_2000, 32'hCAFE_F00D, 2'b11, ALL_HIGH, a, b);
        checks++;
        if (a.writeCycles !== 0 || a.doneK !== 1 || a.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_size_spec got writes=%0d done=%0d err=%b want 0 1 1", a.writeCycles, a.doneK, a.err);
        end
    endtask

    task automatic test_stall_timeout();
        txn_t a, b;
        // Periods 1..3 stalled, handshake in period 4, done in period 5.
        runTxn("stall3", 32'h0000_2000, 32'h0BAD_F00D, 2'b10, 40'hFF_FFFF_FFF1, a, b);
        checks++;
        if (a.hs !== 1 || a.doneK !== 5 || a.err !== 1'b0) begin
            failures++;
            $display("FAIL stall3_spec got hs=%0d done=%0d err=%b want 1 5 0", a.hs, a.doneK, a.err);
        end
        runTxn("timeout_beat0", 32'h0000_3000, 32'h1111_2222, 2'b10, 40'h0, a, b);
        checks++;
        if (a.hs !== 0 || a.writeCycles !== TIMEOUT || a.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_beat0_spec got hs=%0d writes=%0d err=%b want 0 %0d 1", a.hs, a.writeCycles, a.err, TIMEOUT);
        end
        runTxn("timeout_beat1", 32'h0000_3002, 32'h3333_4444, 2'b10, 40'h2, a, b);
        checks++;
        if (a.hs !== 1 || a.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_beat1_spec got hs=%0d err=%b want 1 1", a.hs, a.err);
        end
    endtask

    task automatic test_reset_midop();
        txn_t a, b;
        sample_t s;
        int bad;
        @(negedge clk);
        reqValid = 1'b1; reqAddr = 32'h0000_1002; reqData = 32'h5566_7788; reqSize = 2'b10; memReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; memReady = 1'b1;       // beat 0 accepted at next edge
        @(negedge clk);
        memReady = 1'b0;                        // beat 1 stalls
        #1;
        checks++;
        if (ifA.memWrite !== 1'b1 || ifA.memAddr !== 32'h0000_1004) begin
            failures++;
            $display("FAIL midop_beat1 got write=%b addr=%h want 1 00001004", ifA.memWrite, ifA.memAddr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            s = sampleOf(d);
            checks++;
            if (s.memWrite !== 1'b0 || s.reqReady !== 1'b1 || s.doneValid !== 1'b0) begin
                failures++;
                $display("FAIL midop_reset dut%0d got write=%b ready=%b done=%b want 0 1 0",
                         d, s.memWrite, s.reqReady, s.doneValid);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        memReady = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (ifA.memWrite !== 1'b0 || ifA.doneValid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midop_quiet got %0d active cycles want 0", bad);
        end
        runTxn("after_reset", 32'h0000_4001, 32'hA1B2_C3D4, 2'b10, ALL_HIGH, a, b);
        checks++;
        if (a.hs !== 2 || a.err !== 1'b0 || a.doneK !== 3) begin
            failures++;
            $display("FAIL after_reset_spec got hs=%0d err=%b done=%0d want 2 0 3", a.hs, a.err, a.doneK);
        end
    endtask

    task automatic test_random();
        txn_t a, b;
        logic [31:0] addr;
        logic [39:0] mask;
        for (int n = 0; n < 60; n++) begin
            addr = $urandom;
            if ($urandom_range(3) == 0) addr = {30'h3FFF_FFFF, 2'($urandom)};
            mask = {8'($urandom), 32'($urandom)} | {8'($urandom), 32'($urandom)};
            runTxn("random", addr, $urandom, 2'($urandom), mask, a, b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall_timeout();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
